// File: rtl/and_fold_serial_if.sv
// Handshake bundle for the bit-serial AND reducer: vector input channel,
// 1-bit result channel and the busy indicator.
interface and_fold_serial_if #(
    parameter int N = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [0:N-1] in_x;
    logic         out_valid;
    logic         out_ready;
    logic         out_y;
    logic         busy;

    modport master (
        output in_valid, in_x, out_ready,
        input  in_ready, out_valid, out_y, busy
    );

    modport slave (
        input  in_valid, in_x, out_ready,
        output in_ready, out_valid, out_y, busy
    );
endinterface

// File: rtl/and_fold_serial.sv
// Bit-serial AND reduction: captures an N-bit vector, folds one bit per clock
// (bit 0 at the accept edge) and returns the result over a valid/ready channel.
module and_fold_serial #(
    parameter int N          = 4,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    and_fold_serial_if.slave     bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
    localparam logic [IW-1:0] IDX_FIRST = (N > 1) ? IW'(1) : IW'(0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          acc_q, acc_d;
    logic [0:N-1]  x_q, x_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          out_y_q, out_y_d;
    logic          busy_q, busy_d;
    logic          bit_s;

    // Next-state, datapath and state-decoded output computation.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        x_d         = x_q;
        bit_s       = x_q[idx_q];
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    x_d   = bus.in_x;
                    acc_d = bus.in_x[0];
                    // A single-bit vector, or an early zero, needs no RUN cycle.
                    if ((N == 1) || (EARLY_EXIT && !bus.in_x[0])) begin
                        state_d = S_DONE;
                        idx_d   = {IW{1'b0}};
                    end else begin
                        state_d = S_RUN;
                        idx_d   = IDX_FIRST;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d = acc_q & bit_s;
                if ((idx_q == IDX_LAST) || (EARLY_EXIT && !bit_s)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                    idx_d   = {IW{1'b0}};
                    acc_d   = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = {IW{1'b0}};
                acc_d   = 1'b1;
            end
        endcase

        in_ready_d  = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        out_valid_d = (state_d == S_DONE);
        // The result is latched on entry to DONE and kept after the handshake.
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            out_y_d = acc_d;
        end else begin
            out_y_d = out_y_q;
        end
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= {IW{1'b0}};
            acc_q       <= 1'b1;
            x_q         <= {N{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_y_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            x_q         <= x_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_y     = out_y_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_and_fold_serial.sv
// Scoreboard bench for and_fold_serial: several parameterisations driven by
// directed and random vectors, checked against a behavioural AND model.
module tb_and_fold_serial;
    typedef struct {
        bit y;
        int k;
        int lat;
    } exp_t;

    logic clk;
    logic rst;
    logic rst8;
    int   cyc;
    int   nchk;
    int   npass;
    bit   end_req;
    bit   end_done;
    bit   done4;
    bit   done7;
    logic [3:0] v4;
    logic [6:0] v7;

    exp_t q4[$];
    exp_t q4e[$];
    exp_t q1[$];
    exp_t q8[$];
    exp_t q7[$];
    exp_t mon_e;

    bit   ov_p[5];
    bit   hs_p[5];
    bit   rs_p[5];
    logic y_p[5];

    and_fold_serial_if #(.N(4)) b4  ();
    and_fold_serial_if #(.N(4)) b4e ();
    and_fold_serial_if #(.N(1)) b1  ();
    and_fold_serial_if #(.N(8)) b8  ();
    and_fold_serial_if #(.N(7)) b7  ();

    and_fold_serial #(.N(4), .EARLY_EXIT(1'b0)) u4  (.clk(clk), .rst(rst),  .bus(b4));
    and_fold_serial #(.N(4), .EARLY_EXIT(1'b1)) u4e (.clk(clk), .rst(rst),  .bus(b4e));
    and_fold_serial #(.N(1), .EARLY_EXIT(1'b0)) u1  (.clk(clk), .rst(rst),  .bus(b1));
    and_fold_serial #(.N(8), .EARLY_EXIT(1'b0)) u8  (.clk(clk), .rst(rst8), .bus(b8));
    and_fold_serial #(.N(7), .EARLY_EXIT(1'b1)) u7  (.clk(clk), .rst(rst),  .bus(b7));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Literal bit order: the leftmost literal bit is in_x[0], i.e. v[n-1].
    function automatic exp_t model(input int n, input bit ee, input logic [31:0] v, input int k);
        exp_t e;
        bit   seen;
        e.y   = 1'b1;
        e.lat = n - 1;
        e.k   = k;
        seen  = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (v[n-1-i] == 1'b0) begin
                e.y = 1'b0;
                if (ee && !seen) begin
                    e.lat = i;
                    seen  = 1'b1;
                end
            end
        end
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act == exp) begin
            npass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

`define SEND(IF, Q, NN, EE, VEC) \
    begin \
        bit ok_s; \
        ok_s = 1'b0; \
        IF.in_x = VEC; \
        IF.in_valid = 1'b1; \
        for (int t = 0; t < 500 && !ok_s; t++) begin \
            @(negedge clk); \
            if (IF.in_ready) begin \
                Q.push_back(model(NN, EE, 32'(VEC), cyc + 1)); \
                ok_s = 1'b1; \
            end \
        end \
        if (!ok_s) begin \
            $display("FAIL accept-timeout at cycle %0d", cyc); \
            $fatal(1, "input handshake never completed"); \
        end \
        @(posedge clk); \
        #1; \
        IF.in_valid = 1'b0; \
    end

`define MON(ID, IF, Q, R, NM) \
    if (R) begin \
        ov_p[ID] = 1'b0; \
        hs_p[ID] = 1'b0; \
        rs_p[ID] = 1'b1; \
    end else begin \
        if (rs_p[ID]) begin \
            chk({NM, " reset in_ready"},  int'(IF.in_ready),  1); \
            chk({NM, " reset out_valid"}, int'(IF.out_valid), 0); \
            chk({NM, " reset busy"},      int'(IF.busy),      0); \
            chk({NM, " reset out_y"},     int'(IF.out_y),     0); \
        end \
        chk({NM, " busy vs in_ready"}, int'(IF.busy), int'(!IF.in_ready)); \
        if (hs_p[ID]) begin \
            chk({NM, " out_valid after handshake"}, int'(IF.out_valid), 0); \
            chk({NM, " in_ready after handshake"},  int'(IF.in_ready),  1); \
        end else if (ov_p[ID]) begin \
            chk({NM, " hold out_valid"}, int'(IF.out_valid), 1); \
            chk({NM, " hold out_y"},     int'(IF.out_y),     int'(y_p[ID])); \
            chk({NM, " hold in_ready"},  int'(IF.in_ready),  0); \
        end \
        if (IF.out_valid && !ov_p[ID]) begin \
            chk({NM, " result expected"}, int'(Q.size() > 0), 1); \
            if (Q.size() > 0) chk({NM, " latency"}, cyc - Q[0].k, Q[0].lat); \
        end \
        if (IF.out_valid && IF.out_ready && (Q.size() > 0)) begin \
            mon_e = Q.pop_front(); \
            chk({NM, " out_y"}, int'(IF.out_y), int'(mon_e.y)); \
        end \
        ov_p[ID] = IF.out_valid; \
        y_p[ID]  = IF.out_y; \
        hs_p[ID] = IF.out_valid && IF.out_ready; \
        rs_p[ID] = 1'b0; \
    end

    // Monitor: observes every instance each cycle and pops the scoreboards.
    always @(negedge clk) begin
        `MON(0, b4,  q4,  rst,  "u4")
        `MON(1, b4e, q4e, rst,  "u4e")
        `MON(2, b1,  q1,  rst,  "u1")
        `MON(3, b8,  q8,  rst8, "u8")
        `MON(4, b7,  q7,  rst,  "u7")
        if (end_req && !end_done) begin
            chk("u4 drained",  q4.size(),  0);
            chk("u4e drained", q4e.size(), 0);
            chk("u1 drained",  q1.size(),  0);
            chk("u8 drained",  q8.size(),  0);
            chk("u7 drained",  q7.size(),  0);
            end_done = 1'b1;
        end
    end

    initial begin
        cyc = 0; nchk = 0; npass = 0;
        end_req = 1'b0; end_done = 1'b0; done4 = 1'b0; done7 = 1'b0;
        rst = 1'b1; rst8 = 1'b1;
        b4.in_valid = 1'b0;  b4.in_x = '0;  b4.out_ready = 1'b1;
        b4e.in_valid = 1'b0; b4e.in_x = '0; b4e.out_ready = 1'b1;
        b1.in_valid = 1'b0;  b1.in_x = '0;  b1.out_ready = 1'b1;
        b8.in_valid = 1'b0;  b8.in_x = '0;  b8.out_ready = 1'b1;
        b7.in_valid = 1'b0;  b7.in_x = '0;  b7.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; rst8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Directed vectors, no early exit and with early exit.
        `SEND(b4,  q4,  4, 1'b0, 4'b1111)
        `SEND(b4,  q4,  4, 1'b0, 4'b1101)
        `SEND(b4e, q4e, 4, 1'b1, 4'b1101)
        `SEND(b4e, q4e, 4, 1'b1, 4'b0111)
        `SEND(b4e, q4e, 4, 1'b1, 4'b1111)
        `SEND(b1,  q1,  1, 1'b0, 1'b1)
        `SEND(b1,  q1,  1, 1'b0, 1'b0)
        `SEND(b1,  q1,  1, 1'b0, 1'b1)

        // Backpressure: result parked while in_valid stays high with a toggling vector.
        repeat (6) @(posedge clk);
        #1;
        b4.out_ready = 1'b0;
        `SEND(b4, q4, 4, 1'b0, 4'b1011)
        b4.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            b4.in_x = ~b4.in_x;
        end
        b4.out_ready = 1'b1;
        `SEND(b4, q4, 4, 1'b0, 4'b1111)

        // Reset in the middle of a RUN, then a normal vector.
        `SEND(b8, q8, 8, 1'b0, 8'hF0)
        repeat (2) @(posedge clk);
        #1;
        rst8 = 1'b1;
        @(posedge clk);
        #1;
        q8.delete();
        rst8 = 1'b0;
        `SEND(b8, q8, 8, 1'b0, 8'hFF)

        // Random back-to-back traffic with random consumer stalls.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    v4 = 4'($urandom);
                    if (i % 3 == 0) v4 = 4'b1111;
                    `SEND(b4, q4, 4, 1'b0, v4)
                end
                done4 = 1'b1;
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    v7 = 7'($urandom);
                    if (i % 3 == 0) v7 = 7'h7F;
                    `SEND(b7, q7, 7, 1'b1, v7)
                end
                done7 = 1'b1;
            end
            begin
                while (!(done4 && done7)) begin
                    @(posedge clk);
                    #1;
                    b4.out_ready = 1'($urandom_range(0, 1));
                    b7.out_ready = 1'($urandom_range(0, 1));
                end
                b4.out_ready = 1'b1;
                b7.out_ready = 1'b1;
            end
        join

        for (int t = 0; t < 500 && ((q4.size() + q4e.size() + q1.size() + q8.size() + q7.size()) > 0); t++) begin
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        end_req = 1'b1;
        for (int t = 0; t < 5 && !end_done; t++) begin
            @(posedge clk);
        end
        #1;
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
